button_conditioner: RTL

Parametrised multi-channel front end for the push-button inputs on `ui_in` of the seven-segment animation design. Each channel synchronises a raw button, debounces it with a cycle-count filter, and emits single-cycle press and release pulses. Optionally, it also emits auto-repeat pulses while a button is held, so that holding speed or animation buttons steps repeatedly. It replaces ad-hoc per-button edge logic with one block sized by parameters.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/button_channel.sv | 139 +++++++++++++
 rtl/button_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package btn_pkg;

    // Per-channel auto-repeat state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Width of a counter that must be able to hold the value max_val
    function automatic int cnt_width(input int unsigned max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : btn_pkg

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce filter, press/release pulses, auto-repeat FSM.
// Latency: level and press/release pulse 2+DEBOUNCE_CYCLES cycles after an input change; repeats at +REPEAT_DELAY, then every REPEAT_RATE.
// Backpressure: none; all outputs are free-running registered levels/pulses.
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_RATE     = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int HC_W = cnt_width(REPEAT_DELAY);

    localparam logic [DB_W-1:0] DB_TERM  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HC_W-1:0] DELAY_TC = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0] RATE_TC  = HC_W'(REPEAT_RATE - 1);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    rpt_state_t      r_state;
    logic [HC_W-1:0] r_hold_cnt;

    logic w_sync;
    logic w_db_tc;
    logic w_rise;
    logic w_fall;

    assign w_sync  = r_sync[1];
    // Terminal count takes priority over the current sample, so a toggle
    // back on exactly that edge still flips the level.
    assign w_db_tc = (r_db_cnt == DB_TERM);
    assign w_rise  = w_db_tc & ~r_level;
    assign w_fall  = w_db_tc &  r_level;

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Debounce: count consecutive mismatches, flip the level at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_db_tc) begin
            r_db_cnt <= '0;
            r_level  <= ~r_level;
        end else if (w_sync != r_level) begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Press/release pulses land on the same edge the level changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
        end
    end

    // Auto-repeat FSM; a falling level always wins and suppresses any repeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_repeat   <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (w_fall) begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= '0;
                        end
                    end
                    HOLD: begin
                        if (!i_repeat_en) begin
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == DELAY_TC) begin
                            r_repeat   <= 1'b1;
                            r_state    <= REPEAT;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HC_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!i_repeat_en) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == RATE_TC) begin
                            r_repeat   <= 1'b1;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HC_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule : button_channel

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: optional inversion, then N_BTN independent button_channel instances.
// Latency: 2+DEBOUNCE_CYCLES cycles input-to-level/pulse; repeat pulses REPEAT_DELAY after press, then every REPEAT_RATE.
// Backpressure: none; pulses are single-cycle and must be consumed when presented.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_RATE     = 2000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    logic [N_BTN-1:0] w_btn;

    // Inversion happens ahead of the synchroniser so its reset value means "not pressed"
    assign w_btn = ACTIVE_LOW ? ~btn_in : btn_in;

    genvar g;
    for (g = 0; g < N_BTN; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_btn       (w_btn[g]),
            .i_repeat_en (repeat_en[g]),
            .o_level     (btn_level[g]),
            .o_press     (press_pulse[g]),
            .o_release   (release_pulse[g]),
            .o_repeat    (repeat_pulse[g])
        );
    end

endmodule : button_conditioner
